timestamp_capture: RTL

Downstream consumer of the free-running 16-bit up counter. It timestamps edges of an asynchronous event input with the current counter value and buffers the timestamps in a small FIFO. A valid/ready interface drains the FIFO to a host or bus agent. Used for pulse-width and period measurement.

---
 rtl/timestamp_capture.sv | 133 +++++++++++++
 1 files changed

// File: rtl/timestamp_capture.sv
// Timestamps synchronized edges of an asynchronous event line with a free-running
// counter into a show-ahead FIFO. Optional macro CAPTURE_FALL_EN adds tagged falling-edge capture.
module timestamp_capture #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           counter,
    input  logic                       event_in,
    input  logic                       enable,
`ifdef CAPTURE_FALL_EN
    output logic [WIDTH:0]             ts_data,
`else
    output logic [WIDTH-1:0]           ts_data,
`endif
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_FALL_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [DW-1:0]          r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   r_overflow;

    logic                   w_sync_q;
    logic                   w_rise;
    logic                   w_edge;
    logic [DW-1:0]          w_push_data;
    logic                   w_full;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_prev;

`ifdef CAPTURE_FALL_EN
    logic w_fall;
    assign w_fall      = ~w_sync_q & r_prev;
    assign w_edge      = w_rise | w_fall;
    assign w_push_data = {w_rise, counter};
`else
    assign w_edge      = w_rise;
    assign w_push_data = counter;
`endif

    assign w_valid = (r_count != {(AW+1){1'b0}});
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = w_valid & ts_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push  = enable & w_edge & (~w_full | w_pop);
    assign w_drop  = enable & w_edge & w_full & ~w_pop;

    // Synchronizer chain and edge-history flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], event_in};
            r_prev <= w_sync_q;
        end
    end

    // FIFO storage and write pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Read pointer and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign ts_data    = r_mem[r_rd_ptr];
    assign ts_valid   = w_valid;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
